// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the async instruction memory and queues words for decode.
// Optional `IFU_PERF_CNT_EN adds PerfFetched/PerfFlushed event counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'hF000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Exception,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        InstrReady
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] PerfFetched,
    output logic [31:0] PerfFlushed
`endif
);

    localparam logic [0:0]  ST_ISSUE = 1'b0;
    localparam logic [0:0]  ST_WAIT  = 1'b1;
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          ovalid_q, ovalid_d;
    logic [31:0]   oinstr_q, oinstr_d, opc_q, opc_d;
    logic [SW-1:0] total;
    logic          flush, pop, push, load;

    // The head register is one of the QDEPTH slots, so occupancy is storage plus head.
    always_comb begin
        flush      = Exception | Redirect;
        pop        = ovalid_q & InstrReady;
        total      = scnt_q + SW'(ovalid_q);
        push       = (state_q == ST_WAIT) && (wcnt_q == '0) && !flush;
        load       = !flush && (scnt_q != '0) && (!ovalid_q || pop);
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        scnt_d     = scnt_q;
        ovalid_d   = ovalid_q;
        oinstr_d   = oinstr_q;
        opc_d      = opc_q;

        if (flush) begin
            state_d    = ST_ISSUE;
            wcnt_d     = '0;
            fetch_pc_d = Exception ? EXC_VECTOR : (RedirectPC & 32'hFFFF_FFFC);
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (total < SW'(QDEPTH)) begin
                        wcnt_d  = CW'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - CW'(1);
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_ISSUE;
                    end
                end
                default: state_d = ST_ISSUE;
            endcase
        end

        if (flush) begin
            scnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovalid_d = 1'b0;
        end else begin
            if (load) begin
                ovalid_d          = 1'b1;
                {oinstr_d, opc_d} = mem_q[rd_ptr_q];
                rd_ptr_d          = rd_ptr_q + PW'(1);
            end else if (pop) begin
                ovalid_d = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            scnt_d = scnt_q + SW'(push) - SW'(load);
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= ST_ISSUE;
            wcnt_q     <= '0;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            scnt_q     <= '0;
            ovalid_q   <= 1'b0;
            oinstr_q   <= '0;
            opc_q      <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            scnt_q     <= scnt_d;
            ovalid_q   <= ovalid_d;
            oinstr_q   <= oinstr_d;
            opc_q      <= opc_d;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {ImemData, fetch_pc_q};
        end
    end

    assign ImemAddress = fetch_pc_q;
    assign InstrValid  = ovalid_q;
    assign Instr       = oinstr_q;
    assign InstrPC     = opc_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;

    // Discards: buffered words (minus a head taken this edge) plus the word in flight.
    always_comb begin
        fetched_d = fetched_q + 32'(push);
        flushed_d = flushed_q;
        if (flush) begin
            flushed_d = flushed_q + 32'(scnt_q) + 32'(ovalid_q & ~pop) + 32'(state_q == ST_WAIT);
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign PerfFetched = fetched_q;
    assign PerfFlushed = flushed_q;
`endif

endmodule
